// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, instruction field positions and register-file geometry
package cpu_pkg;
    localparam int REG_AW = 3;
    localparam int NREGS  = 8;
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SHL = 2'b10,
        OP_SHR = 2'b11
    } alu_op_e;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 14;
    localparam int IMM_BIT = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 4;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;
endpackage

// File: rtl/regfile_8x32.sv
// regfile_8x32: 8-entry register file, three combinational read ports, one synchronous write port
//   clk, rst          : clock, synchronous active-high clear of all entries
//   we, waddr, wdata  : write port (writes to r0 are dropped)
//   ra1/rd1, ra2/rd2  : operand read ports
//   ra3/rd3           : debug read port
module regfile_8x32
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [REG_AW-1:0] ra3,
    output logic [DATA_W-1:0] rd3
);
    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) regs_q <= '{default: '0};
        else if (we && waddr != '0) regs_q[waddr] <= wdata;
    end

    assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
    assign rd3 = (ra3 == '0) ? '0 : regs_q[ra3];
endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: issue/writeback stage driving an external 32-bit ALU
//   in_valid/in_ready/in_instr        : instruction stream ({op, use_imm, rd, rs1, rs2|imm7})
//   alu_a/alu_b/alu_op, alu_result    : registered operands to the ALU and its combinational result
//   res_valid/res_ready/res_data/res_rd : registered result stream
//   dbg_addr/dbg_data                 : register-file debug read (no bypass)
module alu_issue_wb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter bit IMM_SEXT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [REG_AW-1:0] res_rd,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    alu_op_e           alu_op_q, alu_op_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [REG_AW-1:0] res_rd_q, res_rd_d;

    logic              wb_free, ex_adv, accept;
    logic              use_imm, byp1, byp2;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [6:0]        imm7;
    logic [DATA_W-1:0] imm_ext, rf_rd1, rf_rd2, op_a, op_b;

    assign wb_free  = !res_valid_q || res_ready;
    assign ex_adv   = ex_valid_q && wb_free;
    assign in_ready = !ex_valid_q || ex_adv;
    assign accept   = in_valid && in_ready;

    assign use_imm = in_instr[IMM_BIT];
    assign rd      = in_instr[RD_MSB:RD_LSB];
    assign rs1     = in_instr[RS1_MSB:RS1_LSB];
    assign rs2     = in_instr[RS2_MSB:RS2_LSB];
    assign imm7    = in_instr[IMM_MSB:IMM_LSB];
    assign imm_ext = IMM_SEXT ? {{(DATA_W-7){imm7[6]}}, imm7} : {{(DATA_W-7){1'b0}}, imm7};

    regfile_8x32 #(.DATA_W(DATA_W)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (ex_adv),
        .waddr (ex_rd_q),
        .wdata (alu_result),
        .ra1   (rs1),
        .rd1   (rf_rd1),
        .ra2   (rs2),
        .rd2   (rf_rd2),
        .ra3   (dbg_addr),
        .rd3   (dbg_data)
    );

    // The result being written this cycle is not yet in the register file, so forward it.
    assign byp1 = ex_adv && ex_rd_q != '0 && ex_rd_q == rs1;
    assign byp2 = ex_adv && ex_rd_q != '0 && ex_rd_q == rs2;
    assign op_a = byp1 ? alu_result : rf_rd1;
    assign op_b = use_imm ? imm_ext : (byp2 ? alu_result : rf_rd2);

    always_comb begin
        ex_valid_d  = accept ? 1'b1 : (ex_adv ? 1'b0 : ex_valid_q);
        alu_a_d     = accept ? op_a : alu_a_q;
        alu_b_d     = accept ? op_b : alu_b_q;
        alu_op_d    = accept ? alu_op_e'(in_instr[OP_MSB:OP_LSB]) : alu_op_q;
        ex_rd_d     = accept ? rd : ex_rd_q;
        res_valid_d = ex_adv ? 1'b1 : (res_ready ? 1'b0 : res_valid_q);
        res_data_d  = ex_adv ? alu_result : res_data_q;
        res_rd_d    = ex_adv ? ex_rd_q : res_rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_ADD;
            ex_rd_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            ex_rd_q     <= ex_rd_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
endmodule
